// File: rtl/wb_arbiter_3to2.sv
// wb_arbiter_3to2: three per-source result FIFOs drained onto two registered
// register-file write ports under round-robin priority.
module wb_arbiter_3to2 #(
    parameter int OPRAND_WIDTH  = 32,
    parameter int REGNAME_WIDTH = 5,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fu0_valid_i,
    input  logic                     fu1_valid_i,
    input  logic                     fu2_valid_i,
    input  logic [REGNAME_WIDTH-1:0] fu0_dest_i,
    input  logic [REGNAME_WIDTH-1:0] fu1_dest_i,
    input  logic [REGNAME_WIDTH-1:0] fu2_dest_i,
    input  logic [OPRAND_WIDTH-1:0]  fu0_data_i,
    input  logic [OPRAND_WIDTH-1:0]  fu1_data_i,
    input  logic [OPRAND_WIDTH-1:0]  fu2_data_i,
    output logic                     fu0_ready_o,
    output logic                     fu1_ready_o,
    output logic                     fu2_ready_o,
    output logic                     write1_en_o,
    output logic                     write2_en_o,
    output logic [REGNAME_WIDTH-1:0] write1_addr_o,
    output logic [REGNAME_WIDTH-1:0] write2_addr_o,
    output logic [OPRAND_WIDTH-1:0]  write1_data_o,
    output logic [OPRAND_WIDTH-1:0]  write2_data_o,
    output logic                     busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [2:0]               w_valid;
    logic [REGNAME_WIDTH-1:0] w_in_dest [3];
    logic [OPRAND_WIDTH-1:0]  w_in_data [3];
    logic [REGNAME_WIDTH-1:0] r_dest [3][FIFO_DEPTH];
    logic [OPRAND_WIDTH-1:0]  r_data [3][FIFO_DEPTH];
    logic [AW-1:0]            r_wp [3];
    logic [AW-1:0]            r_rp [3];
    logic [AW:0]              r_cnt [3];
    logic [1:0]               r_rr;
    logic                     r_en1;
    logic                     r_en2;
    logic [REGNAME_WIDTH-1:0] r_addr1;
    logic [REGNAME_WIDTH-1:0] r_addr2;
    logic [OPRAND_WIDTH-1:0]  r_data1;
    logic [OPRAND_WIDTH-1:0]  r_data2;
    logic [2:0]               w_ready;
    logic [2:0]               w_push;
    logic [2:0]               w_pop;
    logic [2:0]               w_ne;
    logic [REGNAME_WIDTH-1:0] w_head_dest [3];
    logic [OPRAND_WIDTH-1:0]  w_head_data [3];
    logic                     w_g1;
    logic                     w_g2;
    logic [1:0]               w_s1;
    logic [1:0]               w_s2;
    logic [1:0]               w_last;

    assign w_valid   = {fu2_valid_i, fu1_valid_i, fu0_valid_i};
    assign w_in_dest = '{fu0_dest_i, fu1_dest_i, fu2_dest_i};
    assign w_in_data = '{fu0_data_i, fu1_data_i, fu2_data_i};

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            w_ne[i]        = r_cnt[i] != '0;
            w_ready[i]     = rst && (r_cnt[i] != (AW+1)'(FIFO_DEPTH));
            w_push[i]      = w_valid[i] && w_ready[i];
            w_head_dest[i] = r_dest[i][r_rp[i]];
            w_head_data[i] = r_data[i][r_rp[i]];
        end
    end

    // Only the second non-empty candidate may take port 2; a dest clash idles the port
    always_comb begin
        logic [2:0] sum;
        logic [1:0] idx;
        logic       seen;
        w_g1 = 1'b0;
        w_g2 = 1'b0;
        w_s1 = '0;
        w_s2 = '0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sum = {1'b0, r_rr} + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
            if (w_ne[idx]) begin
                if (!w_g1) begin
                    w_g1 = 1'b1;
                    w_s1 = idx;
                end else if (!seen) begin
                    seen = 1'b1;
                    w_g2 = w_head_dest[idx] != w_head_dest[w_s1];
                    w_s2 = idx;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            w_pop[i] = (w_g1 && w_s1 == 2'(i)) || (w_g2 && w_s2 == 2'(i));
    end

    assign w_last = w_g2 ? w_s2 : w_s1;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (w_push[i]) begin
                r_dest[i][r_wp[i]] <= w_in_dest[i];
                r_data[i][r_wp[i]] <= w_in_data[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                r_wp[i]  <= '0;
                r_rp[i]  <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_push[i])
                    r_wp[i] <= r_wp[i] + 1'b1;
                if (w_pop[i])
                    r_rp[i] <= r_rp[i] + 1'b1;
                r_cnt[i] <= r_cnt[i] + (AW+1)'(w_push[i]) - (AW+1)'(w_pop[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rr    <= '0;
            r_en1   <= 1'b0;
            r_en2   <= 1'b0;
            r_addr1 <= '0;
            r_addr2 <= '0;
            r_data1 <= '0;
            r_data2 <= '0;
        end else begin
            r_en1 <= w_g1;
            r_en2 <= w_g2;
            if (w_g1) begin
                r_addr1 <= w_head_dest[w_s1];
                r_data1 <= w_head_data[w_s1];
                r_rr    <= (w_last == 2'd2) ? 2'd0 : w_last + 2'd1;
            end
            if (w_g2) begin
                r_addr2 <= w_head_dest[w_s2];
                r_data2 <= w_head_data[w_s2];
            end
        end
    end

    assign fu0_ready_o   = w_ready[0];
    assign fu1_ready_o   = w_ready[1];
    assign fu2_ready_o   = w_ready[2];
    assign write1_en_o   = r_en1;
    assign write2_en_o   = r_en2;
    assign write1_addr_o = r_addr1;
    assign write2_addr_o = r_addr2;
    assign write1_data_o = r_data1;
    assign write2_data_o = r_data2;
    assign busy_o        = (w_ne != '0) || r_en1 || r_en2;
endmodule

// File: tb/tb_wb_arbiter_3to2.sv
// tb_wb_arbiter_3to2: directed scenarios plus a scoreboarded random run
// for the three-source writeback arbiter.
module tb_wb_arbiter_3to2;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fu0_valid_i = 1'b0, fu1_valid_i = 1'b0, fu2_valid_i = 1'b0;
    logic [4:0]  fu0_dest_i = '0, fu1_dest_i = '0, fu2_dest_i = '0;
    logic [31:0] fu0_data_i = '0, fu1_data_i = '0, fu2_data_i = '0;
    logic        fu0_ready_o, fu1_ready_o, fu2_ready_o;
    logic        write1_en_o, write2_en_o;
    logic [4:0]  write1_addr_o, write2_addr_o;
    logic [31:0] write1_data_o, write2_data_o;
    logic        busy_o;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [1:0]  s;
        logic [4:0]  d;
        logic [31:0] v;
    } ent_t;
    ent_t sb[$];

    always #5 clk = ~clk;

    wb_arbiter_3to2 dut (
        .clk(clk), .rst(rst),
        .fu0_valid_i(fu0_valid_i), .fu1_valid_i(fu1_valid_i), .fu2_valid_i(fu2_valid_i),
        .fu0_dest_i(fu0_dest_i), .fu1_dest_i(fu1_dest_i), .fu2_dest_i(fu2_dest_i),
        .fu0_data_i(fu0_data_i), .fu1_data_i(fu1_data_i), .fu2_data_i(fu2_data_i),
        .fu0_ready_o(fu0_ready_o), .fu1_ready_o(fu1_ready_o), .fu2_ready_o(fu2_ready_o),
        .write1_en_o(write1_en_o), .write2_en_o(write2_en_o),
        .write1_addr_o(write1_addr_o), .write2_addr_o(write2_addr_o),
        .write1_data_o(write1_data_o), .write2_data_o(write2_data_o),
        .busy_o(busy_o)
    );

    task automatic idle_inputs();
        fu0_valid_i = 1'b0;
        fu1_valid_i = 1'b0;
        fu2_valid_i = 1'b0;
    endtask

    // Leaves the bench at a negedge with rst released; the next posedge is edge 1
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({write1_en_o, write2_en_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_en got en1/en2/busy=%b want 000", {write1_en_o, write2_en_o, busy_o});
        end
        checks++;
        if ({fu2_ready_o, fu1_ready_o, fu0_ready_o} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got %b want 000", {fu2_ready_o, fu1_ready_o, fu0_ready_o});
        end
        checks++;
        if ({write1_addr_o, write1_data_o, write2_addr_o, write2_data_o} !== 74'd0) begin
            errors++;
            $display("FAIL reset_addr_data got %h/%h %h/%h want zeros", write1_addr_o, write1_data_o, write2_addr_o, write2_data_o);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({fu2_ready_o, fu1_ready_o, fu0_ready_o, write1_en_o, busy_o} !== 5'b11100) begin
            errors++;
            $display("FAIL reset_release got ready=%b en1=%b busy=%b want 111 0 0", {fu2_ready_o, fu1_ready_o, fu0_ready_o}, write1_en_o, busy_o);
        end
    endtask

    task automatic test_single();
        do_reset();
        fu0_valid_i = 1'b1;
        fu0_dest_i  = 5'd3;
        fu0_data_i  = 32'hA5A5_0001;
        @(negedge clk);
        idle_inputs();
        checks++;
        if ({write1_en_o, busy_o} !== 2'b01) begin
            errors++;
            $display("FAIL single_e1 got en1=%b busy=%b want 0 1", write1_en_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o} !== {1'b1, 5'd3, 32'hA5A5_0001}) begin
            errors++;
            $display("FAIL single_port1 got en=%b addr=%0d data=%h want 1 3 a5a50001", write1_en_o, write1_addr_o, write1_data_o);
        end
        checks++;
        if (write2_en_o !== 1'b0) begin
            errors++;
            $display("FAIL single_port2 got en2=%b want 0", write2_en_o);
        end
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, busy_o} !== {1'b0, 5'd3, 1'b0}) begin
            errors++;
            $display("FAIL single_after got en1=%b addr=%0d busy=%b want 0 3 0", write1_en_o, write1_addr_o, busy_o);
        end
        // rr now points at fu1, so fu1 must win port 1 over fu0
        fu0_valid_i = 1'b1;
        fu0_dest_i  = 5'd10;
        fu0_data_i  = 32'h0000_0100;
        fu1_valid_i = 1'b1;
        fu1_dest_i  = 5'd11;
        fu1_data_i  = 32'h0000_0111;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o} !==
            {1'b1, 5'd11, 32'h111, 1'b1, 5'd10, 32'h100}) begin
            errors++;
            $display("FAIL single_rr got p1=%b/%0d/%h p2=%b/%0d/%h want 1/11/111 1/10/100",
                     write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o);
        end
    endtask

    task automatic test_three();
        do_reset();
        fu0_valid_i = 1'b1; fu0_dest_i = 5'd1; fu0_data_i = 32'h0000_0101;
        fu1_valid_i = 1'b1; fu1_dest_i = 5'd2; fu1_data_i = 32'h0000_0202;
        fu2_valid_i = 1'b1; fu2_dest_i = 5'd4; fu2_data_i = 32'h0000_0404;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o} !==
            {1'b1, 5'd1, 32'h101, 1'b1, 5'd2, 32'h202}) begin
            errors++;
            $display("FAIL three_first got p1=%b/%0d/%h p2=%b/%0d/%h want 1/1/101 1/2/202",
                     write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o);
        end
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o} !==
            {1'b1, 5'd4, 32'h404, 1'b0, 5'd2, 32'h202}) begin
            errors++;
            $display("FAIL three_second got p1=%b/%0d/%h p2=%b/%0d/%h want 1/4/404 0/2/202",
                     write1_en_o, write1_addr_o, write1_data_o, write2_en_o, write2_addr_o, write2_data_o);
        end
        @(negedge clk);
        checks++;
        if ({write1_en_o, write2_en_o, busy_o} !== 3'b000) begin
            errors++;
            $display("FAIL three_idle got en1/en2/busy=%b want 000", {write1_en_o, write2_en_o, busy_o});
        end
    endtask

    task automatic test_conflict();
        do_reset();
        fu0_valid_i = 1'b1; fu0_dest_i = 5'd7; fu0_data_i = 32'hAAAA_0000;
        fu1_valid_i = 1'b1; fu1_dest_i = 5'd7; fu1_data_i = 32'hBBBB_0000;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, write2_en_o} !== {1'b1, 5'd7, 32'hAAAA_0000, 1'b0}) begin
            errors++;
            $display("FAIL conflict_first got p1=%b/%0d/%h en2=%b want 1/7/aaaa0000 0",
                     write1_en_o, write1_addr_o, write1_data_o, write2_en_o);
        end
        @(negedge clk);
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, write2_en_o} !== {1'b1, 5'd7, 32'hBBBB_0000, 1'b0}) begin
            errors++;
            $display("FAIL conflict_second got p1=%b/%0d/%h en2=%b want 1/7/bbbb0000 0",
                     write1_en_o, write1_addr_o, write1_data_o, write2_en_o);
        end
    endtask

    // fu0 and fu2 share dest 9, so only one grant per cycle and fu2 fills up
    task automatic test_fifo_full();
        int          s0 = 0;
        int          s2 = 0;
        int          e;
        bit          a0, a2;
        int          l0[$];
        int          l2[$];
        logic        en;
        logic [31:0] d;
        logic [31:0] exp_d;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            fu0_valid_i = k < 7;
            fu0_dest_i  = 5'd9;
            fu0_data_i  = {2'd0, 30'(s0)};
            fu2_valid_i = s2 < 7;
            fu2_dest_i  = 5'd9;
            fu2_data_i  = {2'd2, 30'(s2)};
            #1;
            a0 = fu0_valid_i && fu0_ready_o;
            a2 = fu2_valid_i && fu2_ready_o;
            @(negedge clk);
            e = k + 1;
            if (a0) s0++;
            if (a2) s2++;
            if (e <= 7) begin
                checks++;
                if ({fu2_ready_o, fu0_ready_o} !== {e != 6, e != 7}) begin
                    errors++;
                    $display("FAIL full_ready e%0d got fu2/fu0=%b%b want %b%b", e, fu2_ready_o, fu0_ready_o, e != 6, e != 7);
                end
                exp_d = (e % 2 == 0) ? {2'd0, 30'(e / 2 - 1)} : {2'd2, 30'((e - 3) / 2)};
                checks++;
                if (e == 1 && {write1_en_o, write2_en_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL full_write e1 got en1/en2=%b%b want 00", write1_en_o, write2_en_o);
                end else if (e > 1 && {write1_en_o, write1_addr_o, write1_data_o, write2_en_o} !== {1'b1, 5'd9, exp_d, 1'b0}) begin
                    errors++;
                    $display("FAIL full_write e%0d got p1=%b/%0d/%h en2=%b want 1/9/%h 0",
                             e, write1_en_o, write1_addr_o, write1_data_o, write2_en_o, exp_d);
                end
            end
            if (e == 7) begin
                checks++;
                if (s2 !== 6) begin
                    errors++;
                    $display("FAIL full_accepted got %0d fu2 pushes before refusal want 6", s2);
                end
            end
            for (int p = 0; p < 2; p++) begin
                en = p ? write2_en_o : write1_en_o;
                d  = p ? write2_data_o : write1_data_o;
                if (en && d[31:30] == 2'd0) l0.push_back(int'(d[29:0]));
                if (en && d[31:30] == 2'd2) l2.push_back(int'(d[29:0]));
            end
        end
        idle_inputs();
        checks++;
        if (l2.size() != 7 || l0.size() != 7) begin
            errors++;
            $display("FAIL full_count got fu0=%0d fu2=%0d writes want 7 7", l0.size(), l2.size());
        end
        for (int j = 0; j < l2.size(); j++) begin
            checks++;
            if (l2[j] != j) begin
                errors++;
                $display("FAIL full_order fu2 write %0d got seq %0d want %0d", j, l2[j], j);
            end
        end
        for (int j = 0; j < l0.size(); j++) begin
            checks++;
            if (l0[j] != j) begin
                errors++;
                $display("FAIL full_order fu0 write %0d got seq %0d want %0d", j, l0[j], j);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL full_drain got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fu1_valid_i = 1'b1;
            fu1_dest_i  = 5'(5 + k);
            fu1_data_i  = 32'h500 + 32'(k);
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if ({write1_en_o, write1_addr_o, write1_data_o, busy_o} !== {1'b1, 5'd6, 32'h501, 1'b1}) begin
            errors++;
            $display("FAIL midrst_pre got p1=%b/%0d/%h busy=%b want 1/6/501 1", write1_en_o, write1_addr_o, write1_data_o, busy_o);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({write1_en_o, write2_en_o, busy_o, fu1_ready_o, write1_addr_o} !== {4'b0000, 5'd0}) begin
            errors++;
            $display("FAIL midrst_reset got en1=%b en2=%b busy=%b ready1=%b addr1=%0d want 0 0 0 0 0",
                     write1_en_o, write2_en_o, busy_o, fu1_ready_o, write1_addr_o);
        end
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({write1_en_o, write2_en_o, busy_o} !== 3'b000) begin
                errors++;
                $display("FAIL midrst_stale cycle %0d got en1/en2/busy=%b want 000", k, {write1_en_o, write2_en_o, busy_o});
            end
        end
    endtask

    task automatic test_random();
        bit [2:0]    pv;
        logic [4:0]  pd [3];
        logic [31:0] pdat [3];
        int          seq [3];
        logic [2:0]  rdy;
        logic        en;
        logic [4:0]  ad;
        logic [31:0] dt;
        int          idx;
        ent_t        item;
        pv  = '0;
        seq = '{0, 0, 0};
        sb.delete();
        do_reset();
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                en = p ? write2_en_o : write1_en_o;
                ad = p ? write2_addr_o : write1_addr_o;
                dt = p ? write2_data_o : write1_data_o;
                if (en) begin
                    idx = -1;
                    for (int j = 0; j < sb.size(); j++)
                        if (idx < 0 && sb[j].s == dt[31:30]) idx = j;
                    checks++;
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL rand_write port%0d got addr=%0d data=%h want no write", p + 1, ad, dt);
                    end else begin
                        if (sb[idx].d !== ad || sb[idx].v !== dt) begin
                            errors++;
                            $display("FAIL rand_write port%0d got addr=%0d data=%h want addr=%0d data=%h",
                                     p + 1, ad, dt, sb[idx].d, sb[idx].v);
                        end
                        sb.delete(idx);
                    end
                end
            end
            if (write1_en_o && write2_en_o) begin
                checks++;
                if (write1_addr_o === write2_addr_o) begin
                    errors++;
                    $display("FAIL rand_same_addr got both ports addr=%0d want distinct", write1_addr_o);
                end
            end
            if (cyc >= 1000 && sb.size() == 0 && !busy_o) break;
            for (int i = 0; i < 3; i++) begin
                if (cyc < 1000 && !pv[i] && $urandom_range(0, 99) < 60) begin
                    pv[i]   = 1'b1;
                    pd[i]   = 5'($urandom_range(0, 7));
                    pdat[i] = {2'(i), 30'(seq[i])};
                    seq[i]++;
                end
                if (cyc >= 1000) pv[i] = 1'b0;
            end
            fu0_valid_i = pv[0]; fu0_dest_i = pd[0]; fu0_data_i = pdat[0];
            fu1_valid_i = pv[1]; fu1_dest_i = pd[1]; fu1_data_i = pdat[1];
            fu2_valid_i = pv[2]; fu2_dest_i = pd[2]; fu2_data_i = pdat[2];
            #1;
            rdy = {fu2_ready_o, fu1_ready_o, fu0_ready_o};
            for (int i = 0; i < 3; i++) begin
                if (pv[i] && rdy[i]) begin
                    item.s = 2'(i);
                    item.d = pd[i];
                    item.v = pdat[i];
                    sb.push_back(item);
                    pv[i] = 1'b0;
                end
            end
            @(negedge clk);
        end
        idle_inputs();
        checks++;
        if (sb.size() != 0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rand_drain got %0d unwritten results busy=%b want 0 0", sb.size(), busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_conflict();
        test_fifo_full();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_arbiter_3to2.md
# wb_arbiter_3to2

Writeback arbiter that collects results from three functional-unit sources and drives the two write ports of the 3-read/2-write register file. Each source has a small FIFO, so a functional unit never stalls unless its own queue is full. Each cycle, up to two queued results are granted onto the write ports under round-robin priority. Both write ports are registered.

## Interface
Parameters:
- OPRAND_WIDTH, 32, result data width
- REGNAME_WIDTH, 5, destination register index width
- FIFO_DEPTH, 4, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- fu0_valid_i, fu1_valid_i, fu2_valid_i  in  1 each  source result valid
- fu0_dest_i, fu1_dest_i, fu2_dest_i  in  REGNAME_WIDTH each  destination register
- fu0_data_i, fu1_data_i, fu2_data_i  in  OPRAND_WIDTH each  result data
- fu0_ready_o, fu1_ready_o, fu2_ready_o  out  1 each  source FIFO can accept
- write1_en_o, write2_en_o  out  1  register-file write enables
- write1_addr_o, write2_addr_o  out  REGNAME_WIDTH  write addresses
- write1_data_o, write2_data_o  out  OPRAND_WIDTH  write data
- busy_o  out  1  any FIFO non-empty or any write enable high

## Operation
- Reset (rst low at an edge): all FIFOs emptied, rr_ptr=0, write1/2_en_o=0, addr/data outputs=0. busy_o=0. fuN_ready_o=0 while rst is low; 1 from the first cycle after release.
- Push: fuN_valid_i && fuN_ready_o at an edge enqueues {dest,data} into FIFO N. fuN_ready_o = !full(N), combinational from the occupancy count only. A full FIFO refuses a push even if it is popped in the same cycle. Valid without ready is ignored; no data is lost on the source side, because the source must hold it.
- Grant: the candidate order is rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty FIFO in that order gets port 1.
  - The next non-empty FIFO gets port 2.
  - Exception: if its head dest equals the port-1 dest, port 2 stays idle this cycle and that head waits.
  - The third source is never granted in the same cycle.
- Pop: each granted FIFO pops at the edge. At the same edge, its head is registered into writeK_en_o/addr_o/data_o. Ungranted ports register en=0 and hold their addr/data values.
- rr_ptr update: set to (index of last granted source + 1) mod 3. Unchanged if nothing is granted.
- Per-source ordering is preserved (FIFO). Results from different sources carry no ordering guarantee.
- No special handling of any register index; dest 0 is written like any other.
- Occupancy counters have width log2(FIFO_DEPTH)+1. Read/write pointers have width log2(FIFO_DEPTH) and wrap naturally.

## Timing
- A push is accepted at edge t. The earliest grant is in cycle t→t+1; the FIFO has no bypass.
- writeK_en_o is high during cycle t+1→t+2, and the register file captures the write at edge t+2.
- Sustained throughput is 2 writes per cycle when at least two sources have non-conflicting heads.
- Simultaneous push and pop on a non-full FIFO: both take effect and the count is unchanged.
- A write enable lasts exactly one cycle per grant. Back-to-back grants keep it high for consecutive cycles.
- Reset mid-operation: all queued and in-flight results are discarded at that edge, and the outputs show reset values in the next cycle.
- busy_o is combinational from the FIFO counts and the registered enables.

## Test plan
- Reset, then push fu0 {dest=3, data=0xA5A5_0001} at edge 1 → write1_en_o=1, addr=3, data=0xA5A5_0001 in cycle 2→3; write2_en_o=0; rr_ptr=1.
- All three sources push in the same cycle (dests 1, 2, 4) with rr_ptr=0 → the next cycle shows port1=fu0/dest1 and port2=fu1/dest2. The cycle after that shows port1=fu2/dest4 and port2 idle.
- fu0 and fu1 both push dest=7 with rr_ptr=0 → port1 writes fu0's data, port2 is idle. The next cycle, port1 writes fu1's data to dest 7.
- Hold fu2_valid_i high with no grants possible (force a full FIFO by pushing 5 times with the arbiter blocked by fu0/fu1 traffic) → fu2_ready_o=0 once 4 entries are queued. The 5th result is accepted only after a pop, and all 5 emerge in order.
- Queue 3 entries in fu1, assert rst low for one edge → the next cycle shows write enables=0, busy_o=0 and fu1_ready_o=0 while rst is low. No stale writes appear after release.
- Continuous random traffic from all sources for 1000 cycles, checked against a scoreboard → every accepted result is written exactly once, per-source order is preserved, and no cycle has two enables on the same address.
